// File: rtl/sudoku_mask_scan.sv
// sudoku_mask_scan: serial one-cell-per-cycle scan of a 729-bit candidate-elimination mask
module sudoku_mask_scan #(
    parameter bit STOP_ON_BAD = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [728:0] mask_in,
    output logic         busy,
    output logic         done,
    output logic         solved,
    output logic         contradiction,
    output logic [6:0]   single_count,
    output logic [6:0]   bad_cell,
    output logic [323:0] cell_val
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    state_t state;
    logic [728:0] mask_q;
    logic [8:0] bits;
    logic [6:0] cnt, idx, sc_next;
    logic fetch, pend, one, zero, last, con_next;
    logic [3:0] ones, val;
    // fetch stage shifts the next cell's bits out of mask_q; eval stage accumulates one cycle later
    always_comb begin
        ones = 4'($countones(bits));
        one = pend && ones == 4'd8;
        zero = pend && ones == 4'd9;
        val = 4'd0;
        for (int i = 0; i < 9; i++) val = bits[i] ? val : 4'(i + 1);
        sc_next = (one && single_count != 7'd81) ? single_count + 7'd1 : single_count;
        con_next = contradiction | zero;
        last = pend && (idx == 7'd80 || (STOP_ON_BAD && zero));
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            mask_q <= '0;
            bits <= '0;
            cnt <= '0;
            idx <= '0;
            fetch <= 1'b0;
            pend <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            solved <= 1'b0;
            contradiction <= 1'b0;
            single_count <= '0;
            bad_cell <= 7'd127;
            cell_val <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mask_q <= mask_in;
                        cnt <= '0;
                        fetch <= 1'b1;
                        pend <= 1'b0;
                        single_count <= '0;
                        contradiction <= 1'b0;
                        solved <= 1'b0;
                        bad_cell <= 7'd127;
                        cell_val <= '0;
                        busy <= 1'b1;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    pend <= fetch;
                    if (fetch) begin
                        bits <= mask_q[8:0];
                        mask_q <= mask_q >> 9;
                        idx <= cnt;
                        cnt <= (cnt == 7'd80) ? cnt : cnt + 7'd1;
                        fetch <= cnt != 7'd80;
                    end
                    if (pend) begin
                        single_count <= sc_next;
                        contradiction <= con_next;
                        cell_val[{idx, 2'b00} +: 4] <= one ? val : 4'd0;
                        if (zero && bad_cell == 7'd127) bad_cell <= idx;
                    end
                    if (last) begin
                        state <= DONE;
                        busy <= 1'b0;
                        done <= 1'b1;
                        fetch <= 1'b0;
                        solved <= sc_next == 7'd81 && !con_next;
                    end
                end
                DONE: begin
                    done <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sudoku_mask_scan.sv
// tb_sudoku_mask_scan: scoreboard bench driving a full-scan and an early-stop instance in parallel
module tb_sudoku_mask_scan;
    logic clk = 1'b0, reset, start;
    logic [728:0] mask_in;
    logic b0, d0, s0, c0, b1, d1, s1, c1;
    logic [6:0] sc0, bad0, sc1, bad1;
    logic [323:0] cv0, cv1;
    typedef struct {
        int t0, lat, sc, bad;
        bit con, sol;
        logic [323:0] cv;
    } exp_t;
    exp_t q0[$], q1[$];
    exp_t e0, e1;
    int n_cmp = 0, n_bad = 0, nd0 = 0, nd1 = 0, cyc = 0, t0 = 0;
    logic [728:0] m;
    logic [323:0] cva, cvb;

    sudoku_mask_scan #(.STOP_ON_BAD(1'b0)) dut0 (
        .clk(clk), .reset(reset), .start(start), .mask_in(mask_in), .busy(b0), .done(d0),
        .solved(s0), .contradiction(c0), .single_count(sc0), .bad_cell(bad0), .cell_val(cv0));
    sudoku_mask_scan #(.STOP_ON_BAD(1'b1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .mask_in(mask_in), .busy(b1), .done(d1),
        .solved(s1), .contradiction(c1), .single_count(sc1), .bad_cell(bad1), .cell_val(cv1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, logic [323:0] act, logic [323:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // digit of a valid solved grid at cell c = x*9+y
    function automatic logic [3:0] dig(int c);
        int x = c / 9, y = c % 9;
        return 4'(((y * 3 + y / 3 + x) % 9) + 1);
    endfunction

    function automatic logic [728:0] grid_mask(int hole);
        logic [728:0] r = '0;
        for (int c = 0; c < 81; c++)
            r[c*9 +: 9] = (c == hole) ? 9'h1FF : (9'h1FF & ~(9'd1 << (dig(c) - 4'd1)));
        return r;
    endfunction

    function automatic logic [323:0] grid_cv(int hole, int limit);
        logic [323:0] r = '0;
        for (int c = 0; c < limit; c++) if (c != hole) r[c*4 +: 4] = dig(c);
        return r;
    endfunction

    function automatic exp_t mk(int lat, int sc, bit con, bit sol, int bad, logic [323:0] cv);
        exp_t e;
        e.t0 = t0; e.lat = lat; e.sc = sc; e.con = con; e.sol = sol; e.bad = bad; e.cv = cv;
        return e;
    endfunction

    always @(negedge clk) if (d0 === 1'b1) begin
        nd0++;
        if (q0.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL dut0 done with empty scoreboard at cycle %0d", cyc);
        end else begin
            e0 = q0.pop_front();
            chk("dut0 latency", 324'(cyc - e0.t0), 324'(e0.lat));
            chk("dut0 single_count", 324'(sc0), 324'(e0.sc));
            chk("dut0 contradiction", 324'(c0), 324'(e0.con));
            chk("dut0 solved", 324'(s0), 324'(e0.sol));
            chk("dut0 bad_cell", 324'(bad0), 324'(e0.bad));
            chk("dut0 cell_val", cv0, e0.cv);
            chk("dut0 busy at done", 324'(b0), 324'(0));
        end
    end

    always @(negedge clk) if (d1 === 1'b1) begin
        nd1++;
        if (q1.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL dut1 done with empty scoreboard at cycle %0d", cyc);
        end else begin
            e1 = q1.pop_front();
            chk("dut1 latency", 324'(cyc - e1.t0), 324'(e1.lat));
            chk("dut1 single_count", 324'(sc1), 324'(e1.sc));
            chk("dut1 contradiction", 324'(c1), 324'(e1.con));
            chk("dut1 solved", 324'(s1), 324'(e1.sol));
            chk("dut1 bad_cell", 324'(bad1), 324'(e1.bad));
            chk("dut1 cell_val", cv1, e1.cv);
        end
    end

    task automatic go(input logic [728:0] mk_mask);
        @(negedge clk);
        mask_in = mk_mask;
        start = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(input int n0, input int n1);
        int k = 0;
        while ((nd0 < n0 || nd1 < n1) && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (nd0 < n0 || nd1 < n1) begin
            n_cmp++; n_bad++;
            $display("FAIL done timeout: got %0d/%0d pulses expected %0d/%0d", nd0, nd1, n0, n1);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " busy"}, 324'({b0, b1}), 324'(0));
        chk({tag, " done"}, 324'({d0, d1}), 324'(0));
        chk({tag, " solved"}, 324'({s0, s1}), 324'(0));
        chk({tag, " contradiction"}, 324'({c0, c1}), 324'(0));
        chk({tag, " single_count"}, 324'({sc0, sc1}), 324'(0));
        chk({tag, " bad_cell"}, 324'({bad0, bad1}), 324'({7'd127, 7'd127}));
        chk({tag, " cell_val"}, cv0 | cv1, '0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b1;
        mask_in = '0;
        repeat (2) @(negedge clk);
        chk_reset("reset");
        reset = 1'b0;
        start = 1'b0;
        // all candidates open everywhere
        go('0);
        q0.push_back(mk(82, 0, 0, 0, 127, '0));
        q1.push_back(mk(82, 0, 0, 0, 127, '0));
        wait_done(1, 1);
        // fully solved grid, then results must hold in IDLE
        go(grid_mask(-1));
        q0.push_back(mk(82, 81, 0, 1, 127, grid_cv(-1, 81)));
        q1.push_back(mk(82, 81, 0, 1, 127, grid_cv(-1, 81)));
        wait_done(2, 2);
        repeat (5) @(negedge clk);
        chk("hold single_count", 324'(sc0), 324'(81));
        chk("hold solved", 324'(s0), 324'(1));
        // dead cell 40: full scan vs early stop
        go(grid_mask(40));
        q0.push_back(mk(82, 80, 1, 0, 40, grid_cv(40, 81)));
        q1.push_back(mk(42, 40, 1, 0, 40, grid_cv(40, 40)));
        wait_done(3, 3);
        // dead cells 5 and 70, singles at 0 (digit 7) and 80 (digit 1)
        m = '0;
        m[5*9 +: 9] = 9'h1FF;
        m[70*9 +: 9] = 9'h1FF;
        m[8:0] = 9'h1BF;
        m[80*9 +: 9] = 9'h1FE;
        cva = '0;
        cva[3:0] = 4'd7;
        cvb = cva;
        cva[323:320] = 4'd1;
        go(m);
        q0.push_back(mk(82, 2, 1, 0, 5, cva));
        q1.push_back(mk(7, 1, 1, 0, 5, cvb));
        wait_done(4, 4);
        // reset in the middle of a scan
        go(grid_mask(-1));
        repeat (29) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_reset("midscan reset");
        q0.delete();
        q1.delete();
        repeat (100) @(negedge clk);
        chk("no done after abort", 324'({nd0, nd1}), 324'({32'd4, 32'd4}));
        go(grid_mask(-1));
        q0.push_back(mk(82, 81, 0, 1, 127, grid_cv(-1, 81)));
        q1.push_back(mk(82, 81, 0, 1, 127, grid_cv(-1, 81)));
        wait_done(5, 5);
        // start pulse and mask changes during a scan are ignored
        go(grid_mask(-1));
        q0.push_back(mk(82, 81, 0, 1, 127, grid_cv(-1, 81)));
        q1.push_back(mk(82, 81, 0, 1, 127, grid_cv(-1, 81)));
        repeat (20) @(negedge clk);
        start = 1'b1;
        mask_in = {729{1'b1}};
        @(negedge clk);
        start = 1'b0;
        mask_in = '0;
        wait_done(6, 6);
        repeat (100) @(negedge clk);
        chk("single done per start", 324'({nd0, nd1}), 324'({32'd6, 32'd6}));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
